// File: rtl/mem_copy_master_if.sv
// PicoRV32 native memory bus bundle shared by the copy master and its responder.
interface mem_copy_master_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_copy_master.sv
// Block copy initiator on the PicoRV32 native memory bus: read word, write word, repeat.
// Optional per-transfer ready timeout enabled by defining MCM_TIMEOUT_EN.
module mem_copy_master #(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] xfer_count,
    mem_copy_master_if.master bus
);

    typedef enum logic [2:0] {StIdle, StRd, StRdGap, StWr, StWrGap, StDone} state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [31:0]       buf_q, buf_d;

`ifdef MCM_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`else
    // The limit is meaningless without the timeout counter.
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_param_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (len_words != '0) begin
                        src_d   = {src_addr[31:2], 2'b00};
                        dst_d   = {dst_addr[31:2], 2'b00};
                        rem_d   = len_words;
                        busy_d  = 1'b1;
                        valid_d = 1'b1;
                        addr_d  = {src_addr[31:2], 2'b00};
                        wstrb_d = 4'h0;
                        state_d = StRd;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRd: begin
                if (bus.mem_ready) begin
                    buf_d   = bus.mem_rdata;
                    valid_d = 1'b0;
                    state_d = StRdGap;
                end
            end
            StRdGap: begin
                valid_d = 1'b1;
                addr_d  = dst_q;
                wstrb_d = 4'hF;
                wdata_d = buf_q;
                state_d = StWr;
            end
            StWr: begin
                if (bus.mem_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + LEN_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    state_d = StWrGap;
                end
            end
            StWrGap: begin
                if (rem_q == '0) begin
                    state_d = StDone;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = src_q;
                    wstrb_d = 4'h0;
                    state_d = StRd;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef MCM_TIMEOUT_EN
        // Counter is only live while a transfer stalls; any other state clears it.
        tmo_d = '0;
        if ((state_q == StRd || state_q == StWr) && !bus.mem_ready) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = StDone;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
`ifdef MCM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
`ifdef MCM_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign xfer_count    = cnt_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: RAM responder with programmable ready latency,
// write scoreboard, and handshake stability / gap monitors.
module tb_mem_copy_master;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, err;
    logic [LEN_W-1:0] xfer_count;

    mem_copy_master_if bus ();

    mem_copy_master #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder: RAM of 1024 words indexed by addr[11:2].
    logic [31:0] mem [0:1023];
    int unsigned lat = 0;
    bit          never_wr = 1'b0;
    int unsigned wait_cnt = 0;

    assign bus.mem_ready = bus.mem_valid && !(never_wr && bus.mem_wstrb != 4'h0) &&
                           (wait_cnt >= lat);
    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (reset || !bus.mem_valid || bus.mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t         exp_q[$];
    logic [31:0] rd_log[$];
    int          valid_cnt = 0;

    bit          rst_at_edge = 1'b1;
    bit          prev_pend = 1'b0;
    bit          prev_cmp = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;

    always @(posedge clk) rst_at_edge = reset;

    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_valid) valid_cnt++;
        if (!reset && bus.mem_valid && bus.mem_ready) begin
            if (bus.mem_wstrb == 4'hF) begin
                mem[bus.mem_addr[11:2]] = bus.mem_wdata;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                        n_fail++;
                        $display("FAIL write_sb got addr=%h data=%h want addr=%h data=%h",
                                 bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                    end
                end
            end else begin
                rd_log.push_back(bus.mem_addr);
            end
        end
        if (prev_pend && !rst_at_edge && !err) begin
            n_checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== p_addr ||
                bus.mem_wdata !== p_wdata || bus.mem_wstrb !== p_wstrb) begin
                n_fail++;
                $display("FAIL hold_stable got v=%b a=%h d=%h s=%h want v=1 a=%h d=%h s=%h",
                         bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                         p_addr, p_wdata, p_wstrb);
            end
        end
        if (prev_cmp && !rst_at_edge) begin
            n_checks++;
            if (bus.mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_cycle got valid=%b want 0", bus.mem_valid);
            end
        end
        prev_pend = !reset && bus.mem_valid && !bus.mem_ready;
        prev_cmp  = !reset && bus.mem_valid && bus.mem_ready;
        p_addr    = bus.mem_addr;
        p_wdata   = bus.mem_wdata;
        p_wstrb   = bus.mem_wstrb;
    end

    // Issue one command; cyc = posedges from start edge to done (-1 if never seen).
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int l,
                           output int cyc, output logic busy_after, output logic err_after);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = LEN_W'(l);
        start     = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
        err_after  = err;
        cyc        = -1;
        for (int k = 0; k < 400; k++) begin
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.mem_valid, busy, done, err} !== 4'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0 || xfer_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values got v=%b b=%b d=%b e=%b a=%h w=%h s=%h c=%0d want all 0",
                     bus.mem_valid, busy, done, err, bus.mem_addr, bus.mem_wdata,
                     bus.mem_wstrb, xfer_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_copy();
        int cyc;
        logic b, e;
        lat = 0;
        mem[12'h100 >> 2] = 32'h1111_1111;
        mem[12'h104 >> 2] = 32'h2222_2222;
        mem[12'h108 >> 2] = 32'h3333_3333;
        exp_q.push_back('{32'h200, 32'h1111_1111});
        exp_q.push_back('{32'h204, 32'h2222_2222});
        exp_q.push_back('{32'h208, 32'h3333_3333});
        run_cmd(32'h100, 32'h200, 3, cyc, b, e);
        n_checks++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", b); end
        n_checks++;
        if (cyc != 13) begin n_fail++; $display("FAIL basic_done_latency got %0d want 13", cyc); end
        n_checks++;
        if (busy !== 1'b0 || xfer_count !== 16'd3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status got busy=%b cnt=%0d err=%b want 0 3 0", busy, xfer_count, err);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || xfer_count !== 16'd3) begin
            n_fail++;
            $display("FAIL basic_pulse got done=%b cnt=%0d want 0 3", done, xfer_count);
        end
        n_checks++;
        if (mem[12'h200 >> 2] !== 32'h1111_1111 || mem[12'h204 >> 2] !== 32'h2222_2222 ||
            mem[12'h208 >> 2] !== 32'h3333_3333 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_mem got %h %h %h pending=%0d want 11111111 22222222 33333333 0",
                     mem[12'h200 >> 2], mem[12'h204 >> 2], mem[12'h208 >> 2], exp_q.size());
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        logic b, e;
        lat = 2;
        mem[12'h140 >> 2] = 32'hCAFE_0001;
        mem[12'h144 >> 2] = 32'hCAFE_0002;
        exp_q.push_back('{32'h240, 32'hCAFE_0001});
        exp_q.push_back('{32'h244, 32'hCAFE_0002});
        // Low address bits must be ignored.
        run_cmd(32'h143, 32'h242, 2, cyc, b, e);
        n_checks++;
        if (cyc != 17) begin n_fail++; $display("FAIL wait_done_latency got %0d want 17", cyc); end
        n_checks++;
        if (xfer_count !== 16'd2 || exp_q.size() != 0 || mem[12'h244 >> 2] !== 32'hCAFE_0002) begin
            n_fail++;
            $display("FAIL wait_copy got cnt=%0d pending=%0d m=%h want 2 0 cafe0002",
                     xfer_count, exp_q.size(), mem[12'h244 >> 2]);
        end
        lat = 0;
    endtask

    task automatic test_zero_len();
        int cyc;
        logic b, e;
        valid_cnt = 0;
        run_cmd(32'h100, 32'h200, 0, cyc, b, e);
        n_checks++;
        if (cyc != 1) begin n_fail++; $display("FAIL zero_done_latency got %0d want 1", cyc); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (valid_cnt != 0 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_bus got valid_cycles=%0d busy=%b want 0 0", valid_cnt, b);
        end
    endtask

    task automatic test_addr_wrap();
        int cyc;
        logic b, e;
        mem[1023] = 32'hAAAA_0001;
        mem[0]    = 32'hAAAA_0002;
        exp_q.push_back('{32'h300, 32'hAAAA_0001});
        exp_q.push_back('{32'h304, 32'hAAAA_0002});
        rd_log.delete();
        run_cmd(32'hFFFF_FFFC, 32'h300, 2, cyc, b, e);
        n_checks++;
        if (cyc != 9) begin n_fail++; $display("FAIL wrap_done_latency got %0d want 9", cyc); end
        n_checks++;
        if (rd_log.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_reads got %0d reads want 2", rd_log.size());
        end else if (rd_log[0] !== 32'hFFFF_FFFC || rd_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_reads got %h %h want fffffffc 00000000", rd_log[0], rd_log[1]);
        end
        n_checks++;
        if (err !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_status got err=%b pending=%0d want 0 0", err, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic b, e;
        bit hit;
        lat = 3;
        for (int i = 0; i < 4; i++) begin
            mem[(12'h180 >> 2) + i] = 32'h5500_0000 + 32'(i);
            mem[(12'h280 >> 2) + i] = 32'hDEAD_BEEF;
        end
        exp_q.push_back('{32'h280, 32'h5500_0000});
        @(negedge clk);
        src_addr  = 32'h180;
        dst_addr  = 32'h280;
        len_words = 16'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.mem_valid && bus.mem_wstrb == 4'hF && xfer_count == 16'd1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rstmid_reach_wr2 got 0 want 1"); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got valid=%b busy=%b want 0 0", bus.mem_valid, busy);
        end
        reset     = 1'b0;
        valid_cnt = 0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (valid_cnt != 0 || mem[12'h284 >> 2] !== 32'hDEAD_BEEF ||
            mem[12'h280 >> 2] !== 32'h5500_0000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_abandon got vcyc=%0d m1=%h m0=%h pend=%0d want 0 deadbeef 55000000 0",
                     valid_cnt, mem[12'h284 >> 2], mem[12'h280 >> 2], exp_q.size());
        end
        lat = 0;
        exp_q.push_back('{32'h2C0, 32'h5500_0000});
        exp_q.push_back('{32'h2C4, 32'h5500_0001});
        run_cmd(32'h180, 32'h2C0, 2, cyc, b, e);
        n_checks++;
        if (cyc != 9 || xfer_count !== 16'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_recopy got cyc=%0d cnt=%0d pend=%0d want 9 2 0",
                     cyc, xfer_count, exp_q.size());
        end
    endtask

`ifdef MCM_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        logic b, e;
        never_wr = 1'b1;
        mem[12'h100 >> 2] = 32'h7777_7777;
        run_cmd(32'h100, 32'h3C0, 1, cyc, b, e);
        n_checks++;
        if (cyc != 11 || err !== 1'b1 || xfer_count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort got cyc=%0d err=%b cnt=%0d busy=%b want 11 1 0 0",
                     cyc, err, xfer_count, busy);
        end
        never_wr = 1'b0;
        exp_q.push_back('{32'h3C0, 32'h7777_7777});
        run_cmd(32'h100, 32'h3C0, 1, cyc, b, e);
        n_checks++;
        if (e !== 1'b0 || cyc != 5 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear got err_after_start=%b cyc=%0d want 0 5", e, cyc);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_basic_copy();
        test_wait_states();
        test_zero_len();
        test_addr_wrap();
        test_reset_mid();
`ifdef MCM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Copies a block of 32-bit words from a source address to a destination address through any native-interface responder: on-chip RAM, the MMIO window, or the multiplier result registers.
- Lets the system move data without CPU load/store loops.
- Sits beside picorv32_core and shares the responder through the system's arbiter.

Parameters:
- LEN_W, 16, width of the word-count input and the progress counter.
- TIMEOUT_CYCLES, 1024, maximum wait for mem_ready per transfer. Used only with MCM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len_words  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- xfer_count  out  LEN_W  number of words fully written so far.
- mem_valid  out  1  transfer request.
- mem_instr  out  1  tied 0.
- mem_addr  out  32  transfer address, word aligned.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for a write; 4'h0 for a read.
- mem_ready  in  1  responder completes the transfer in this cycle.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1 during a read.

Behaviour:
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, err=0, xfer_count=0, state=IDLE.
- All outputs are registered.
- Handshake:
  - A transfer is presented with mem_valid=1. mem_addr, mem_wdata and mem_wstrb stay stable until the cycle where mem_valid&&mem_ready.
  - Completion occurs in that cycle.
  - On a read, mem_rdata is captured into the data buffer on that edge.
  - mem_valid is low for exactly one cycle after every completed transfer (GAP states).
  - mem_ready while mem_valid=0 is ignored.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE:
  - start && len_words!=0: latch cur_src, cur_dst and remaining. Clear xfer_count and err. Set busy=1. Go to RD.
  - start && len_words==0: go to DONE; no bus activity.
- RD: mem_valid=1, mem_wstrb=0, mem_addr=cur_src. On mem_ready, capture the buffer and go to RD_GAP.
- RD_GAP: mem_valid=0. Go to WR.
- WR: mem_valid=1, mem_wstrb=4'hF, mem_addr=cur_dst, mem_wdata=buffer. On mem_ready:
  - xfer_count += 1, remaining -= 1.
  - cur_src += 4, cur_dst += 4.
  - Go to WR_GAP.
- WR_GAP: mem_valid=0. If remaining==0, go to DONE; else go to RD.
- DONE: done=1 for one cycle, busy=0 on the same edge. Go to IDLE.
- Latency with zero-wait responder (ready=1 continuously): 4 cycles per word. The done pulse occurs 4*N+1 cycles after the start edge.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Overlapping src/dst ranges are copied in ascending order with no hazard protection. A forward overlap propagates the first word.
- start while busy: ignored; no state change.
- Reset mid-operation: the next edge forces all reset values. An in-flight write is abandoned and no further bus requests are made.
- xfer_count holds its final value after done until the next accepted start.

Optional Feature:
- Macro: MCM_TIMEOUT_EN.
- Defined:
  - A per-transfer counter clears on entry to RD/WR and increments each cycle mem_valid=1 && !mem_ready.
  - When the counter reaches TIMEOUT_CYCLES, drop mem_valid on the next edge, set err=1, and go to DONE (done pulse, busy=0).
  - xfer_count reflects the words completed before the timeout.
- Undefined: no counter; the master waits indefinitely for mem_ready; err is constant 0.

Test Plan:
- Zero-wait RAM model, src=0x100 holding 0x11111111, 0x22222222, 0x33333333, dst=0x200, len=3 → words at 0x200..0x208 match; done 13 cycles after start; xfer_count=3; err=0.
- Responder with 2-cycle ready latency, len=2 → mem_addr/mem_wstrb/mem_wdata stable while waiting; one idle cycle of mem_valid after each completion; copy correct.
- len=0 with start → done pulse after 1 cycle; mem_valid never asserted.
- src=0xFFFFFFFC, dst=0x300, len=2 → second read address is 0x00000000; no err.
- Reset asserted during WR of word 2 of 4 → mem_valid=0, busy=0 next cycle; no further writes; a new start afterwards copies correctly.
- With MCM_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never ready on the first write → err=1; done pulse after 8 stalled cycles; xfer_count=0; next start clears err.
